fpmul_scheduler: RTL and testbench

Shares one pipelined FP multiplier (single-precision, fixed latency, no stall input) among N requesters. Round-robin arbitration picks at most one operand pair per cycle and drives the multiplier's FP_A/FP_B from registers. A tag pipeline tracks the owner of each in-flight product and returns each result to its requester. The block sits between the operand producers and the FPmul instance, which the block's parent instantiates.

---
 rtl/fpmul_scheduler.sv | 141 ++++++++++++++
 tb/tb_fpmul_scheduler.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpmul_scheduler.sv
// rtl/fpmul_scheduler.sv - round-robin scheduler sharing one pipelined FP multiplier among N requesters
module fpmul_scheduler #(
  parameter int N     = 4,
  parameter int LAT   = 4,
  parameter int CNT_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ENABLE,
  input  logic              FLUSH,
  input  logic [N-1:0]      REQ_VALID,
  output logic [N-1:0]      REQ_READY,
  input  logic [32*N-1:0]   REQ_A,
  input  logic [32*N-1:0]   REQ_B,
  output logic [31:0]       MUL_A,
  output logic [31:0]       MUL_B,
  input  logic [31:0]       MUL_Z,
  output logic [N-1:0]      RES_VALID,
  output logic [31:0]       RES_DATA,
  output logic              BUSY,
  output logic [CNT_W-1:0]  OPS_CNT
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  // Round-robin pointer and the operand registers feeding the multiplier
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [31:0]      mul_a_q, mul_a_d;
  logic [31:0]      mul_b_q, mul_b_d;

  // Tag pipeline: stage 0 is loaded on the transfer edge, stage LAT-1 holds
  // the tag one cycle before its product appears on MUL_Z. The result strobe
  // register below is the final slot, aligned with MUL_Z.
  logic [LAT-1:0]   tag_vld_q;
  logic [IDX_W-1:0] tag_id_q [LAT];

  logic [N-1:0]     res_valid_q, res_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             gnt_any;
  logic [IDX_W-1:0] gnt_idx;
  logic [N-1:0]     gnt_oh;
  logic [IDX_W-1:0] cand_idx;
  logic             last_fire;

  // Search for the first valid requester from the pointer upward with wrap
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    gnt_oh   = '0;
    cand_idx = '0;
    for (int off = 0; off < N; off++) begin
      cand_idx = IDX_W'((int'(ptr_q) + off) % N);
      if (!gnt_any && REQ_VALID[cand_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = cand_idx;
      end
    end
    if (!ENABLE || FLUSH) begin
      gnt_any = 1'b0;
    end
    if (gnt_any) begin
      gnt_oh[gnt_idx] = 1'b1;
    end
  end

  assign REQ_READY = gnt_oh;

  // Next-state for operands, pointer, result strobe and completed-op counter
  always_comb begin
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    ptr_d       = ptr_q;
    res_valid_d = '0;
    last_fire   = tag_vld_q[LAT-1] && !FLUSH;
    if (gnt_any) begin
      for (int i = 0; i < N; i++) begin
        if (gnt_oh[i]) begin
          mul_a_d = REQ_A[32*i +: 32];
          mul_b_d = REQ_B[32*i +: 32];
        end
      end
      ptr_d = (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + IDX_W'(1);
    end
    if (FLUSH) begin
      ptr_d = '0;
    end
    if (last_fire) begin
      res_valid_d[tag_id_q[LAT-1]] = 1'b1;
    end
    cnt_d = cnt_q + CNT_W'(last_fire);
  end

  // Register operands, pointer, result strobe and counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      res_valid_q <= '0;
      cnt_q       <= '0;
    end else begin
      ptr_q       <= ptr_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      res_valid_q <= res_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  // Shift the tag pipeline every cycle; FLUSH invalidates every stage
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tag_vld_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        tag_id_q[i] <= '0;
      end
    end else begin
      tag_id_q[0] <= gnt_idx;
      for (int i = 1; i < LAT; i++) begin
        tag_id_q[i] <= tag_id_q[i-1];
      end
      if (FLUSH) begin
        tag_vld_q <= '0;
      end else begin
        tag_vld_q[0] <= gnt_any;
        for (int i = 1; i < LAT; i++) begin
          tag_vld_q[i] <= tag_vld_q[i-1];
        end
      end
    end
  end

  assign MUL_A     = mul_a_q;
  assign MUL_B     = mul_b_q;
  assign RES_VALID = res_valid_q;
  assign RES_DATA  = MUL_Z;
  assign BUSY      = |tag_vld_q;
  assign OPS_CNT   = cnt_q;

endmodule

// File: tb/tb_fpmul_scheduler.sv
// tb/tb_fpmul_scheduler.sv - scoreboard bench for fpmul_scheduler with a behavioural FP multiplier
module tb_fpmul_scheduler;

  localparam int N     = 4;
  localparam int LAT   = 4;
  localparam int CNT_W = 4;

  logic              CLK = 1'b0;
  logic              RST;
  logic              ENABLE;
  logic              FLUSH;
  logic [N-1:0]      REQ_VALID;
  logic [N-1:0]      REQ_READY;
  logic [32*N-1:0]   REQ_A;
  logic [32*N-1:0]   REQ_B;
  logic [31:0]       MUL_A;
  logic [31:0]       MUL_B;
  logic [31:0]       MUL_Z;
  logic [N-1:0]      RES_VALID;
  logic [31:0]       RES_DATA;
  logic              BUSY;
  logic [CNT_W-1:0]  OPS_CNT;

  fpmul_scheduler #(.N(N), .LAT(LAT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .FLUSH(FLUSH),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_A(REQ_A), .REQ_B(REQ_B),
    .MUL_A(MUL_A), .MUL_B(MUL_B), .MUL_Z(MUL_Z),
    .RES_VALID(RES_VALID), .RES_DATA(RES_DATA), .BUSY(BUSY), .OPS_CNT(OPS_CNT)
  );

  always #5 CLK = ~CLK;

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) * f2r(b));
  endfunction

  function automatic logic [31:0] itof(input int n);
    return r2f(real'(n));
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Multiplier model: product of the operands present LAT edges earlier
  logic [31:0] zp [LAT];
  always @(posedge CLK) begin
    zp[0] <= fmul(MUL_A, MUL_B);
    for (int i = 1; i < LAT; i++) zp[i] <= zp[i-1];
  end
  assign MUL_Z = zp[LAT-1];

  typedef struct {
    int          due;
    int          id;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp;
  int   n_fail;
  int   cyc;
  int   ops_exp;

  task automatic tracker();
    exp_t e;
    int   g;
    forever begin
      @(posedge CLK);
      cyc++;
      if (RST || FLUSH) begin
        sb.delete();
      end else if ((REQ_VALID & REQ_READY) != '0) begin
        g = 0;
        for (int i = 0; i < N; i++) if (REQ_READY[i]) g = i;
        e.due  = cyc + LAT;
        e.id   = g;
        e.data = fmul(REQ_A[32*g +: 32], REQ_B[32*g +: 32]);
        sb.push_back(e);
      end
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RST) continue;
      if (RES_VALID !== '0) begin
        ops_exp++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL result_unexpected: RES_VALID=%b at cycle %0d, required no result", RES_VALID, cyc);
        end else begin
          e = sb.pop_front();
          if (RES_VALID !== onehot(e.id) || RES_DATA !== e.data || cyc != e.due) begin
            n_fail++;
            $display("FAIL result: RES_VALID=%b RES_DATA=%h cycle=%0d, required %b %h cycle=%0d",
                     RES_VALID, RES_DATA, cyc, onehot(e.id), e.data, e.due);
          end
        end
        n_cmp++;
        if (OPS_CNT !== CNT_W'(ops_exp)) begin
          n_fail++;
          $display("FAIL ops_cnt: got %0d, required %0d", OPS_CNT, CNT_W'(ops_exp));
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        n_cmp++;
        n_fail++;
        $display("FAIL result_missing: no RES_VALID at cycle %0d, required id %0d", cyc, sb[0].id);
        void'(sb.pop_front());
      end
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge CLK);
    while (BUSY !== 1'b0 && t < 40) begin
      @(negedge CLK);
      t++;
    end
    n_cmp++;
    if (BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_timeout: BUSY=%b after 40 cycles, required 0", BUSY);
    end
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    REQ_VALID = '1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    n_cmp++; if (MUL_A !== 32'd0) begin n_fail++; $display("FAIL reset_mul_a: got %h, required 0", MUL_A); end
    n_cmp++; if (MUL_B !== 32'd0) begin n_fail++; $display("FAIL reset_mul_b: got %h, required 0", MUL_B); end
    n_cmp++; if (RES_VALID !== '0) begin n_fail++; $display("FAIL reset_res_valid: got %b, required 0", RES_VALID); end
    n_cmp++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", BUSY); end
    n_cmp++; if (OPS_CNT !== '0) begin n_fail++; $display("FAIL reset_ops_cnt: got %0d, required 0", OPS_CNT); end
    n_cmp++; if (REQ_READY !== 4'b0001) begin n_fail++; $display("FAIL reset_pointer: REQ_READY=%b, required 0001", REQ_READY); end
    REQ_VALID = '0;
    RST = 1'b0;
    ops_exp = 0;
    @(negedge CLK);
  endtask

  task automatic test_single();
    @(posedge CLK); #1;
    REQ_A[64 +: 32] = 32'h40000000;
    REQ_B[64 +: 32] = 32'h40400000;
    REQ_VALID = 4'b0100;
    @(negedge CLK);
    n_cmp++; if (REQ_READY !== 4'b0100) begin n_fail++; $display("FAIL single_grant: got %b, required 0100", REQ_READY); end
    @(posedge CLK); #1;
    REQ_VALID = '0;
    for (int j = 0; j < LAT; j++) begin
      @(negedge CLK);
      n_cmp++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL single_busy: cycle k+%0d BUSY=%b, required 1", j, BUSY); end
    end
    @(negedge CLK);
    n_cmp++; if (RES_VALID !== 4'b0100) begin n_fail++; $display("FAIL single_res_valid: got %b, required 0100", RES_VALID); end
    n_cmp++; if (RES_DATA !== 32'h40C00000) begin n_fail++; $display("FAIL single_res_data: got %h, required 40c00000", RES_DATA); end
    n_cmp++; if (OPS_CNT !== CNT_W'(1)) begin n_fail++; $display("FAIL single_ops_cnt: got %0d, required 1", OPS_CNT); end
    n_cmp++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL single_busy_drop: got %b, required 0", BUSY); end
    n_cmp++; if (MUL_A !== 32'h40000000) begin n_fail++; $display("FAIL single_mul_a_hold: got %h, required 40000000", MUL_A); end
    wait_idle();
  endtask

  task automatic test_all_valid();
    int g;
    @(posedge CLK); #1;
    for (int i = 0; i < N; i++) begin
      REQ_A[32*i +: 32] = itof(i + 1);
      REQ_B[32*i +: 32] = itof(i + 2);
    end
    REQ_VALID = '1;
    g = 3;
    for (int j = 0; j < 12; j++) begin
      @(negedge CLK);
      n_cmp++; if (REQ_READY !== onehot(g)) begin n_fail++; $display("FAIL rr_order: step %0d got %b, required %b", j, REQ_READY, onehot(g)); end
      @(posedge CLK); #1;
      REQ_A[32*g +: 32] = itof(j + 3 + g);
      g = (g + 1) % N;
    end
    REQ_VALID = '0;
    wait_idle();
  endtask

  task automatic test_fairness();
    int seq [4] = '{3, 1, 3, 1};
    @(posedge CLK); #1;
    REQ_VALID = 4'b0010;
    @(negedge CLK);
    n_cmp++; if (REQ_READY !== 4'b0010) begin n_fail++; $display("FAIL fair_setup: got %b, required 0010", REQ_READY); end
    @(posedge CLK); #1;
    REQ_VALID = 4'b1010;
    for (int j = 0; j < 4; j++) begin
      @(negedge CLK);
      n_cmp++; if (REQ_READY !== onehot(seq[j])) begin n_fail++; $display("FAIL fair_alternate: step %0d got %b, required %b", j, REQ_READY, onehot(seq[j])); end
      @(posedge CLK); #1;
    end
    REQ_VALID = '0;
    wait_idle();
  endtask

  task automatic test_flush();
    @(posedge CLK); #1;
    REQ_VALID = '1;
    repeat (3) @(posedge CLK);
    #1;
    FLUSH = 1'b1;
    @(negedge CLK);
    n_cmp++; if (REQ_READY !== '0) begin n_fail++; $display("FAIL flush_ready: got %b, required 0", REQ_READY); end
    n_cmp++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL flush_busy_before: got %b, required 1", BUSY); end
    @(posedge CLK); #1;
    FLUSH = 1'b0;
    REQ_VALID = '0;
    @(negedge CLK);
    n_cmp++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL flush_busy_after: got %b, required 0", BUSY); end
    REQ_VALID = '1;
    #1;
    n_cmp++; if (REQ_READY !== 4'b0001) begin n_fail++; $display("FAIL flush_pointer: REQ_READY=%b, required 0001", REQ_READY); end
    REQ_VALID = '0;
    repeat (LAT + 2) @(negedge CLK);
    n_cmp++; if (OPS_CNT !== CNT_W'(ops_exp)) begin n_fail++; $display("FAIL flush_ops_cnt: got %0d, required %0d", OPS_CNT, CNT_W'(ops_exp)); end
  endtask

  task automatic test_enable();
    @(posedge CLK); #1;
    REQ_A[32 +: 32] = itof(7);
    REQ_B[32 +: 32] = itof(9);
    REQ_VALID = 4'b0010;
    @(negedge CLK);
    n_cmp++; if (REQ_READY !== 4'b0010) begin n_fail++; $display("FAIL enable_first: got %b, required 0010", REQ_READY); end
    @(posedge CLK); #1;
    ENABLE = 1'b0;
    REQ_A[96 +: 32] = itof(5);
    REQ_B[96 +: 32] = itof(6);
    REQ_VALID = 4'b1010;
    for (int j = 0; j < LAT; j++) begin
      @(negedge CLK);
      n_cmp++; if (REQ_READY !== '0) begin n_fail++; $display("FAIL enable_ready: cycle %0d got %b, required 0", j, REQ_READY); end
      n_cmp++; if (MUL_A !== itof(7) || MUL_B !== itof(9)) begin n_fail++; $display("FAIL enable_hold: MUL_A=%h MUL_B=%h, required %h %h", MUL_A, MUL_B, itof(7), itof(9)); end
      n_cmp++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL enable_busy: cycle %0d got %b, required 1", j, BUSY); end
    end
    @(negedge CLK);
    n_cmp++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL enable_busy_drop: got %b, required 0", BUSY); end
    @(posedge CLK); #1;
    ENABLE = 1'b1;
    @(negedge CLK);
    n_cmp++; if (REQ_READY !== 4'b1000) begin n_fail++; $display("FAIL enable_resume: got %b, required 1000", REQ_READY); end
    @(posedge CLK); #1;
    REQ_VALID = '0;
    @(negedge CLK);
    n_cmp++; if (MUL_A !== itof(5)) begin n_fail++; $display("FAIL enable_load: MUL_A=%h, required %h", MUL_A, itof(5)); end
    wait_idle();
  endtask

  task automatic test_async_reset();
    @(posedge CLK); #1;
    for (int i = 0; i < N; i++) begin
      REQ_A[32*i +: 32] = itof(i + 3);
      REQ_B[32*i +: 32] = itof(2);
    end
    REQ_VALID = '1;
    repeat (7) @(posedge CLK);
    #3;
    RST = 1'b1;
    sb.delete();
    ops_exp = 0;
    #1;
    n_cmp++; if (MUL_A !== 32'd0 || MUL_B !== 32'd0) begin n_fail++; $display("FAIL arst_mul: MUL_A=%h MUL_B=%h, required 0 0", MUL_A, MUL_B); end
    n_cmp++; if (RES_VALID !== '0) begin n_fail++; $display("FAIL arst_res_valid: got %b, required 0", RES_VALID); end
    n_cmp++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %b, required 0", BUSY); end
    n_cmp++; if (OPS_CNT !== '0) begin n_fail++; $display("FAIL arst_ops_cnt: got %0d, required 0", OPS_CNT); end
    n_cmp++; if (REQ_READY !== 4'b0001) begin n_fail++; $display("FAIL arst_pointer: REQ_READY=%b, required 0001", REQ_READY); end
    REQ_VALID = '0;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    repeat (LAT + 3) @(negedge CLK);
    n_cmp++; if (OPS_CNT !== '0) begin n_fail++; $display("FAIL arst_no_late_result: OPS_CNT=%0d, required 0", OPS_CNT); end
  endtask

  task automatic test_wrap();
    @(posedge CLK); #1;
    REQ_A[0 +: 32] = itof(2);
    REQ_B[0 +: 32] = itof(1);
    REQ_VALID = 4'b0001;
    for (int j = 0; j < 17; j++) begin
      @(negedge CLK);
      n_cmp++; if (REQ_READY !== 4'b0001) begin n_fail++; $display("FAIL wrap_grant: op %0d got %b, required 0001", j, REQ_READY); end
      @(posedge CLK); #1;
      REQ_B[0 +: 32] = itof(j + 2);
    end
    REQ_VALID = '0;
    wait_idle();
    n_cmp++; if (OPS_CNT !== CNT_W'(1)) begin n_fail++; $display("FAIL wrap_ops_cnt: got %0d, required 1", OPS_CNT); end
  endtask

  initial begin
    RST       = 1'b1;
    ENABLE    = 1'b1;
    FLUSH     = 1'b0;
    REQ_VALID = '0;
    REQ_A     = '0;
    REQ_B     = '0;
    n_cmp     = 0;
    n_fail    = 0;
    cyc       = 0;
    ops_exp   = 0;
    fork
      tracker();
      monitor();
    join_none
    test_reset();
    test_single();
    test_all_valid();
    test_fairness();
    test_flush();
    test_enable();
    test_async_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
